// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_if
// Brief    : Valid/ready handshake bundle for the upstream and downstream sides
// Revision : 1.0
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Stage side: consumes the upstream request and presents the downstream one.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Environment side: drives upstream payload and downstream acceptance.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Two-entry skid buffer pipeline stage with flush and perf counters.
//            Counters exist only when PIPE_SKID_STAGE_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module pipe_skid_stage #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           flush,
    pipe_skid_stage_if.slave    bus,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_kill_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              r_out_valid;

    logic w_push;
    logic w_pop;

    // Handshake qualifiers use only registered flags, so in_ready has no
    // combinational dependence on out_ready.
    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = r_out_valid && bus.out_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE_VAL;
            r_skid      <= BUBBLE_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_main      <= bus.in_data;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_main <= bus.in_data;
                    end else if (w_push) begin
                        r_skid     <= bus.in_data;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        // Main returns to the bubble so out_data is clean when idle.
                        r_main      <= BUBBLE_VAL;
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_skid     <= BUBBLE_VAL;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main      <= BUBBLE_VAL;
                    r_skid      <= BUBBLE_VAL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_kill_cnt;
    logic [1:0]  w_held;
    logic [1:0]  w_kill_n;
    logic [32:0] w_kill_sum;
    logic        w_stall;

    always_comb begin
        w_held = 2'd0;
        case (r_state)
            ST_ONE:  w_held = 2'd1;
            ST_FULL: w_held = 2'd2;
            default: w_held = 2'd0;
        endcase
    end

    // A pop during flush was taken downstream, so it is not a kill.
    assign w_kill_n   = flush ? (w_held - {1'b0, w_pop}) : 2'd0;
    assign w_kill_sum = {1'b0, r_kill_cnt} + {31'd0, w_kill_n};
    assign w_stall    = r_out_valid && !bus.out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_kill_cnt  <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            r_kill_cnt <= w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_kill_cnt  = r_kill_cnt;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_kill_cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 64, sets the payload width in bits; legal range 1..512.
REQ-002 Parameter BUBBLE_VAL, default {DATA_W{1'b0}}, is the payload driven whenever no valid entry is presented.
REQ-003 Port clk, input, 1, is the clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-005 Port flush, input, 1, kills all held entries (branch/jump redirect).
REQ-006 Port in_valid, input, 1, means the upstream stage presents in_data.
REQ-007 Port in_ready, output, 1, means the stage accepts in_data this cycle.
REQ-008 Port in_data, input, DATA_W, is the upstream payload.
REQ-009 Port out_valid, output, 1, means out_data is a valid entry.
REQ-010 Port out_ready, input, 1, means downstream consumes out_data this cycle.
REQ-011 Port out_data, output, DATA_W, is the payload presented to the next stage.
REQ-012 Port perf_stall_cnt, output, 32, counts backpressure cycles.
REQ-013 Port perf_kill_cnt, output, 32, counts entries discarded by flush.

Function
REQ-014 Storage SHALL be two registered entries: main (drives out_data) and skid.
REQ-015 State SHALL be one of EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
REQ-016 push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-017 in_ready SHALL be a function of registered state only (state != FULL), with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-019 EMPTY: push -> main <= in_data, ONE; otherwise EMPTY.
REQ-020 ONE: push&&pop -> main <= in_data, stay ONE; push only -> skid <= in_data, FULL; pop only -> EMPTY; neither -> hold.
REQ-021 FULL: pop -> main <= skid, ONE; otherwise hold; no push possible.
REQ-022 Latency from accepted input to out_valid SHALL be exactly 1 cycle when the stage is EMPTY or popping in ONE.
REQ-023 Ordering SHALL be strict FIFO; no entry may be duplicated or lost except by flush/rst.
REQ-024 out_data SHALL remain stable while out_valid && !out_ready.
REQ-025 out_data SHALL equal BUBBLE_VAL in every cycle where out_valid = 0.
REQ-026 Priority SHALL be rst > flush > normal operation.
REQ-027 flush SHALL force state EMPTY next cycle, and out_data SHALL become BUBBLE_VAL.
REQ-028 A push coinciding with flush SHALL be discarded, and a pop coinciding with flush SHALL still count as consumed downstream.
REQ-029 flush && pop in ONE SHALL kill 0 entries; flush in FULL without pop SHALL kill 2.

Reset
REQ-030 On rst: state EMPTY, out_valid 0, out_data BUBBLE_VAL, skid cleared to BUBBLE_VAL, perf counters 0.
REQ-031 in_ready SHALL read 1 from the first cycle after rst deasserts.
REQ-032 rst asserted mid-transfer SHALL drop all held entries without incrementing perf_kill_cnt.

Configuration
REQ-033 Macro PIPE_SKID_STAGE_PERF_EN: when defined, the perf counters are implemented.
- perf_stall_cnt increments by 1 each cycle with out_valid && !out_ready && !flush.
- perf_kill_cnt adds the number of valid entries killed (0, 1 or 2) per REQ-029.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-034 Without PIPE_SKID_STAGE_PERF_EN: both perf ports stay present and are driven constant 0; no counter flops are synthesised.

Verification
REQ-035 DATA_W=64, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, in_ready constantly 1.
REQ-036 out_ready=0, push 0xA then 0xB -> FULL, in_ready=0; 0xC held off; out_ready=1 -> outputs 0xA,0xB,0xC in order, none lost.
REQ-037 FULL with 0xA,0xB plus flush, no pop -> next cycle out_valid=0, out_data=BUBBLE_VAL, perf_kill_cnt += 2 (macro on).
REQ-038 flush with concurrent push 0x77 in EMPTY -> 0x77 never appears, state EMPTY.
REQ-039 rst while FULL -> next cycle all outputs at reset values, perf_kill_cnt unchanged at 0.
REQ-040 Macro off, 10 backpressure cycles -> perf_stall_cnt=0; macro on, same stimulus -> perf_stall_cnt=10.
